adc_axil_regs: RTL and testbench

//  AXI4-Lite slave register file for the AD9643 LVDS capture path; the responder side of the AXI-Lite master.

---
 rtl/adc_regs_pkg.sv | 38 +++
 rtl/adc_sat_counter.sv | 35 +++
 rtl/adc_axil_regs.sv | 175 +++++++++++++++++
 tb/tb_adc_axil_regs.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_regs_pkg
//  Purpose  : Register map, CTRL field layout and AXI response codes for the
//             AD9643 capture-path AXI4-Lite register file.
//  Revision : 1.0  initial release
// ============================================================================
package adc_regs_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_OVR_CNT = 2'd2,
        REG_ID      = 2'd3
    } reg_sel_e;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_SOFT_RST_BIT  = 1;
    localparam int CTRL_TAP_LSB       = 4;
    localparam int CTRL_TAP_W         = 5;
    localparam int CTRL_TEST_MODE_BIT = 12;

    // Bits of CTRL that hold state; soft reset is a strobe and is never stored
    localparam logic [31:0] CTRL_STORE_MASK = 32'h0000_11F1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sat_counter
//  Purpose  : Saturating event counter; a clear in the same cycle as an
//             increment leaves the count at one.
//  Revision : 1.0  initial release
// ============================================================================
module adc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= {{(WIDTH-1){1'b0}}, i_inc};
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/adc_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : adc_axil_regs
//  Purpose  : AXI4-Lite register file for the AD9643 LVDS capture path:
//             CTRL fields, STATUS, saturating overflow count and ID.
//  Revision : 1.0  initial release
// ============================================================================
module adc_axil_regs
    import adc_regs_pkg::*;
#(
    parameter int          ADDR_WIDTH = 4,
    parameter logic [31:0] ID_VALUE   = 32'hAD96_4301,
    parameter int          OVR_CNT_W  = 16
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  adc_ready_i,
    input  logic                  adc_or_pulse_i,
    output logic                  ctrl_enable_o,
    output logic                  ctrl_soft_rst_o,
    output logic [4:0]            ctrl_idelay_tap_o,
    output logic                  ctrl_idelay_load_o,
    output logic                  ctrl_test_mode_o
);

    logic                 r_alive;
    logic                 r_aw_held;
    reg_sel_e             r_aw_sel;
    logic                 r_w_held;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic [31:0]          r_ctrl;
    logic                 r_soft_rst_pulse;
    logic                 r_idelay_load_pulse;

    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_ar_hs;
    logic                 w_commit;
    logic                 w_ovr_clr;
    logic [31:0]          w_byte_mask;
    logic [31:0]          w_rd_mux;
    reg_sel_e             w_ar_sel;
    logic [OVR_CNT_W-1:0] w_ovr_cnt;
    logic                 w_unused;

    // Readies stay low until the first edge after reset release
    assign s_axi_awready = r_alive & ~r_aw_held & ~r_bvalid;
    assign s_axi_wready  = r_alive & ~r_w_held & ~r_bvalid;
    assign s_axi_arready = r_alive & ~r_rvalid;

    assign w_aw_hs     = s_axi_awvalid & s_axi_awready;
    assign w_w_hs      = s_axi_wvalid & s_axi_wready;
    assign w_ar_hs     = s_axi_arvalid & s_axi_arready;
    assign w_commit    = r_aw_held & r_w_held;
    assign w_ovr_clr   = w_commit & (r_aw_sel == REG_OVR_CNT);
    assign w_byte_mask = strb_to_mask(r_wstrb);
    assign w_ar_sel    = reg_sel_e'(s_axi_araddr[3:2]);

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_alive             <= 1'b0;
            r_aw_held           <= 1'b0;
            r_aw_sel            <= REG_CTRL;
            r_w_held            <= 1'b0;
            r_wdata             <= '0;
            r_wstrb             <= '0;
            r_bvalid            <= 1'b0;
            r_bresp             <= RESP_OKAY;
            r_ctrl              <= '0;
            r_soft_rst_pulse    <= 1'b0;
            r_idelay_load_pulse <= 1'b0;
        end else begin
            r_alive             <= 1'b1;
            r_soft_rst_pulse    <= 1'b0;
            r_idelay_load_pulse <= 1'b0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_sel  <= reg_sel_e'(s_axi_awaddr[3:2]);
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= ((r_aw_sel == REG_STATUS) || (r_aw_sel == REG_ID))
                             ? RESP_SLVERR : RESP_OKAY;
                if (r_aw_sel == REG_CTRL) begin
                    r_ctrl              <= (r_ctrl & ~w_byte_mask)
                                         | (r_wdata & w_byte_mask & CTRL_STORE_MASK);
                    r_soft_rst_pulse    <= r_wstrb[0] & r_wdata[CTRL_SOFT_RST_BIT];
                    r_idelay_load_pulse <= r_wstrb[0] | r_wstrb[1];
                end
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_ar_sel)
            REG_CTRL:    w_rd_mux = r_ctrl;
            REG_STATUS:  w_rd_mux = {30'b0, |w_ovr_cnt, adc_ready_i};
            REG_OVR_CNT: w_rd_mux = 32'(w_ovr_cnt);
            REG_ID:      w_rd_mux = ID_VALUE;
            default:     w_rd_mux = '0;
        endcase
    end

    // Read data is a snapshot from the AR handshake edge, so it sees pre-write state
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    adc_sat_counter #(
        .WIDTH (OVR_CNT_W)
    ) u_ovr_cnt (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .i_inc   (adc_or_pulse_i),
        .i_clr   (w_ovr_clr),
        .o_count (w_ovr_cnt)
    );

    assign s_axi_bvalid       = r_bvalid;
    assign s_axi_bresp        = r_bresp;
    assign s_axi_rvalid       = r_rvalid;
    assign s_axi_rdata        = r_rdata;
    assign s_axi_rresp        = RESP_OKAY;
    assign ctrl_enable_o      = r_ctrl[CTRL_ENABLE_BIT];
    assign ctrl_idelay_tap_o  = r_ctrl[CTRL_TAP_LSB +: CTRL_TAP_W];
    assign ctrl_test_mode_o   = r_ctrl[CTRL_TEST_MODE_BIT];
    assign ctrl_soft_rst_o    = r_soft_rst_pulse;
    assign ctrl_idelay_load_o = r_idelay_load_pulse;

endmodule
`default_nettype wire

// File: tb/tb_adc_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_axil_regs
//  Purpose  : Directed self-checking bench for adc_axil_regs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_axil_regs;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_aresetn;
    logic [3:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        adc_ready_i;
    logic        adc_or_pulse_i;
    logic        ctrl_enable_o;
    logic        ctrl_soft_rst_o;
    logic [4:0]  ctrl_idelay_tap_o;
    logic        ctrl_idelay_load_o;
    logic        ctrl_test_mode_o;

    int errors = 0;
    int checks = 0;
    int n_soft = 0;
    int n_load = 0;

    always #5 s_axi_aclk = ~s_axi_aclk;

    always @(negedge s_axi_aclk) begin
        if (ctrl_soft_rst_o)    n_soft++;
        if (ctrl_idelay_load_o) n_load++;
    end

    adc_axil_regs dut (
        .s_axi_aclk         (s_axi_aclk),
        .s_axi_aresetn      (s_axi_aresetn),
        .s_axi_awaddr       (s_axi_awaddr),
        .s_axi_awprot       (s_axi_awprot),
        .s_axi_awvalid      (s_axi_awvalid),
        .s_axi_awready      (s_axi_awready),
        .s_axi_wdata        (s_axi_wdata),
        .s_axi_wstrb        (s_axi_wstrb),
        .s_axi_wvalid       (s_axi_wvalid),
        .s_axi_wready       (s_axi_wready),
        .s_axi_bresp        (s_axi_bresp),
        .s_axi_bvalid       (s_axi_bvalid),
        .s_axi_bready       (s_axi_bready),
        .s_axi_araddr       (s_axi_araddr),
        .s_axi_arprot       (s_axi_arprot),
        .s_axi_arvalid      (s_axi_arvalid),
        .s_axi_arready      (s_axi_arready),
        .s_axi_rdata        (s_axi_rdata),
        .s_axi_rresp        (s_axi_rresp),
        .s_axi_rvalid       (s_axi_rvalid),
        .s_axi_rready       (s_axi_rready),
        .adc_ready_i        (adc_ready_i),
        .adc_or_pulse_i     (adc_or_pulse_i),
        .ctrl_enable_o      (ctrl_enable_o),
        .ctrl_soft_rst_o    (ctrl_soft_rst_o),
        .ctrl_idelay_tap_o  (ctrl_idelay_tap_o),
        .ctrl_idelay_load_o (ctrl_idelay_load_o),
        .ctrl_test_mode_o   (ctrl_test_mode_o)
    );

    // Bus tasks start and end on a falling edge
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        logic aw_done, w_done, aw_go, w_go;
        int k;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; k = 0;
        while (!(aw_done && w_done) && k < 50) begin
            aw_go = s_axi_awvalid && s_axi_awready;
            w_go  = s_axi_wvalid && s_axi_wready;
            @(negedge s_axi_aclk); k++;
            if (aw_go) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
            if (w_go)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
        end
        k = 0;
        while (!s_axi_bvalid && k < 50) begin @(negedge s_axi_aclk); k++; end
        if (!s_axi_bvalid) begin
            errors++; checks++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, s_axi_bvalid);
        end
        resp = s_axi_bresp;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge s_axi_aclk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int k;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1; k = 0;
        while (!s_axi_arready && k < 50) begin @(negedge s_axi_aclk); k++; end
        @(negedge s_axi_aclk);
        s_axi_arvalid = 1'b0; k = 0;
        while (!s_axi_rvalid && k < 50) begin @(negedge s_axi_aclk); k++; end
        if (!s_axi_rvalid) begin
            errors++; checks++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, s_axi_rvalid);
        end
        d = s_axi_rdata; resp = s_axi_rresp;
        @(negedge s_axi_aclk);
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r;
        s_axi_aresetn = 1'b0;
        repeat (2) @(negedge s_axi_aclk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0
            || s_axi_rdata !== 32'h0 || s_axi_bresp !== 2'b00
            || {ctrl_enable_o, ctrl_soft_rst_o, ctrl_idelay_tap_o, ctrl_idelay_load_o, ctrl_test_mode_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b%b%b bv=%b rv=%b rdata=%h required all 0",
                     s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_rdata);
        end
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        axi_read(4'hC, d, r);
        checks++;
        if (d !== 32'hAD96_4301 || r !== 2'b00) begin
            errors++; $display("FAIL read_id: %h/%b required ad964301/00", d, r);
        end
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL read_ctrl_reset: %h required 0", d); end
    endtask

    task automatic test_ctrl_write();
        logic [31:0] d; logic [1:0] r;
        n_soft = 0; n_load = 0;
        axi_write(4'h0, 32'h0000_1153, 4'hF, r);
        repeat (3) @(negedge s_axi_aclk);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL ctrl_bresp: %b required 00", r); end
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h0000_1151) begin errors++; $display("FAIL ctrl_readback: %h required 00001151", d); end
        checks++;
        if (ctrl_enable_o !== 1'b1 || ctrl_idelay_tap_o !== 5'h15 || ctrl_test_mode_o !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_fields: en=%b tap=%h tm=%b required 1/15/1",
                     ctrl_enable_o, ctrl_idelay_tap_o, ctrl_test_mode_o);
        end
        checks++;
        if (n_soft !== 1 || n_load !== 1) begin
            errors++; $display("FAIL ctrl_pulses: soft=%0d load=%0d required 1/1", n_soft, n_load);
        end
        n_soft = 0; n_load = 0;
        axi_write(4'h0, 32'hFFFF_FFFF, 4'h0, r);
        repeat (3) @(negedge s_axi_aclk);
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h0000_1151 || n_soft !== 0 || n_load !== 0) begin
            errors++;
            $display("FAIL ctrl_strb0: %h soft=%0d load=%0d required 00001151/0/0", d, n_soft, n_load);
        end
        axi_write(4'h0, 32'h0000_0000, 4'h2, r);
        repeat (3) @(negedge s_axi_aclk);
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h0000_0051 || n_soft !== 0 || n_load !== 1 || ctrl_idelay_tap_o !== 5'h05) begin
            errors++;
            $display("FAIL ctrl_byte1: %h soft=%0d load=%0d tap=%h required 00000051/0/1/05",
                     d, n_soft, n_load, ctrl_idelay_tap_o);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [1:0] r;
        int k;
        n_load = 0;
        s_axi_awaddr = 4'h0; s_axi_wdata = 32'h0000_0001; s_axi_wstrb = 4'h1;
        s_axi_bready = 1'b0; s_axi_wvalid = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_wvalid = 1'b0;
        checks++;
        if (s_axi_wready !== 1'b0 || s_axi_awready !== 1'b1) begin
            errors++; $display("FAIL w_held: wready=%b awready=%b required 0/1", s_axi_wready, s_axi_awready);
        end
        repeat (2) @(negedge s_axi_aclk);
        s_axi_awvalid = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_awvalid = 1'b0; k = 0;
        while (!s_axi_bvalid && k < 10) begin @(negedge s_axi_aclk); k++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold[%0d]: bv=%b awr=%b wr=%b required 1/0/0",
                         i, s_axi_bvalid, s_axi_awready, s_axi_wready);
            end
            @(negedge s_axi_aclk);
        end
        checks++;
        if (s_axi_bresp !== 2'b00) begin errors++; $display("FAIL b_hold_resp: %b required 00", s_axi_bresp); end
        s_axi_bready = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_bready = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1 || n_load !== 1) begin
            errors++;
            $display("FAIL b_release: bv=%b awr=%b wr=%b load=%0d required 0/1/1/1",
                     s_axi_bvalid, s_axi_awready, s_axi_wready, n_load);
        end
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL w_first_readback: %h required 00000001", d); end
    endtask

    task automatic test_status_slverr();
        logic [31:0] d; logic [1:0] r;
        adc_ready_i = 1'b1;
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL status_write_resp: %b required 10", r); end
        axi_write(4'hC, 32'h0, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL id_write_resp: %b required 10", r); end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL status_read: %h required 00000001", d); end
        axi_read(4'hC, d, r);
        checks++;
        if (d !== 32'hAD96_4301) begin errors++; $display("FAIL id_after_write: %h required ad964301", d); end
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL ctrl_after_slverr: %h required 00000001", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic [1:0] r;
        for (int i = 0; i < 3; i++) begin
            adc_or_pulse_i = 1'b1; @(negedge s_axi_aclk);
            adc_or_pulse_i = 1'b0; @(negedge s_axi_aclk);
        end
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL ovr_cnt_3: %h required 00000003", d); end
        adc_or_pulse_i = 1'b1;
        repeat (70000) @(negedge s_axi_aclk);
        adc_or_pulse_i = 1'b0;
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL ovr_cnt_sat: %h required 0000ffff", d); end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL status_ovr: %h required 00000003", d); end
        // Both channels handshake together; the pulse lands in the commit cycle
        s_axi_awaddr = 4'h8; s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF; s_axi_bready = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; adc_or_pulse_i = 1'b1;
        @(negedge s_axi_aclk);
        adc_or_pulse_i = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            errors++; $display("FAIL clr_bresp: bv=%b resp=%b required 1/00", s_axi_bvalid, s_axi_bresp);
        end
        s_axi_bready = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_bready = 1'b0;
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL clr_with_pulse: %h required 00000001", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d; logic [1:0] r;
        s_axi_araddr = 4'h0; s_axi_rready = 1'b0; s_axi_arvalid = 1'b1;
        @(negedge s_axi_aclk);
        s_axi_arvalid = 1'b0;
        @(negedge s_axi_aclk);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h1 || s_axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_held: rv=%b rdata=%h arr=%b required 1/00000001/0",
                     s_axi_rvalid, s_axi_rdata, s_axi_arready);
        end
        #2 s_axi_aresetn = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'h0 || s_axi_arready !== 1'b0
            || s_axi_awready !== 1'b0 || ctrl_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: rv=%b rdata=%h arr=%b awr=%b en=%b required 0/0/0/0/0",
                     s_axi_rvalid, s_axi_rdata, s_axi_arready, s_axi_awready, ctrl_enable_o);
        end
        @(negedge s_axi_aclk);
        s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);
        axi_read(4'h0, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ctrl_after_reset: %h required 0", d); end
        axi_read(4'h8, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ovr_after_reset: %h required 0", d); end
        axi_read(4'h4, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL status_after_reset: %h required 00000001", d); end
    endtask

    initial begin
        s_axi_aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        adc_ready_i = 1'b0; adc_or_pulse_i = 1'b0;
        @(negedge s_axi_aclk);
        test_reset();
        test_ctrl_write();
        test_w_before_aw();
        test_status_slverr();
        test_overflow();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
